// File: rtl/dsp_ctrl_pkg.sv
// rtl/dsp_ctrl_pkg.sv - state encoding and OPMODE constants for the DSP MAC sequencer
package dsp_ctrl_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] FEED   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    // X = M, Z = P: the slice computes P <= P + M
    localparam logic [7:0] OPMODE_ACC  = 8'b0000_1001;
    localparam logic [7:0] OPMODE_IDLE = 8'h00;

endpackage

// File: rtl/ce_pipe.sv
// rtl/ce_pipe.sv - two-stage clock-enable shift register tracking operands through the M and P registers
module ce_pipe (
    input  logic CLK,
    input  logic clr,
    input  logic accept,
    output logic CEM,
    output logic CEP
);

    logic [1:0] ce_sr;

    always_ff @(posedge CLK) begin
        if (clr) begin
            ce_sr <= 2'b00;
        end else begin
            ce_sr <= {ce_sr[0], accept};
        end
    end

    assign CEM = ce_sr[0];
    assign CEP = ce_sr[1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - sequences a DSP48A1-style slice as a length-N MAC; DSP_MAC_ABORT_EN adds an abort input
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int         LEN_WIDTH  = 8,
    parameter int         P_WIDTH    = 48,
    parameter logic [7:0] OPMODE_ACC = dsp_ctrl_pkg::OPMODE_ACC
) (
    input  logic                 CLK,
    input  logic                 RST,
`ifdef DSP_MAC_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 CEA,
    output logic                 CEB,
    output logic                 CEM,
    output logic                 CEP,
    output logic                 RSTP,
    output logic [7:0]           OPMODE,
    input  logic [P_WIDTH-1:0]   P_IN,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [P_WIDTH-1:0]   res_data,
    output logic                 busy
);

    logic [2:0]           state;
    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 accept;
    logic                 last_accept;
    logic                 abort_hit;
    logic                 ce_clr;

`ifdef DSP_MAC_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign in_ready    = (state == FEED);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (count == len_q - 1'b1);
    assign ce_clr      = RST || abort_hit;

    ce_pipe u_ce_pipe (
        .CLK    (CLK),
        .clr    (ce_clr),
        .accept (accept),
        .CEM    (CEM),
        .CEP    (CEP)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            count    <= '0;
            len_q    <= '0;
            res_data <= '0;
        end else if (abort_hit) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_q <= len;
                        count <= '0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= FEED;
                end
                FEED: begin
                    if (accept) begin
                        count <= count + 1'b1;
                    end
                    if (last_accept) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Both CE stages empty means the final product has landed in P
                    if (!CEM && !CEP) begin
                        res_data <= P_IN;
                        state    <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign CEA       = accept;
    assign CEB       = accept;
    assign RSTP      = (state == CLEAR) || abort_hit;
    assign OPMODE    = ((state == FEED) || (state == DRAIN)) ? OPMODE_ACC : OPMODE_IDLE;
    assign res_valid = (state == RESULT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - self-checking bench for dsp_mac_sequencer driving a behavioural DSP slice
module tb_dsp_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic        CEA, CEB, CEM, CEP, RSTP;
    logic [7:0]  OPMODE;
    logic [47:0] P_IN;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        busy;
`ifdef DSP_MAC_ABORT_EN
    logic        abort;
`endif

    always #5 CLK = ~CLK;

    dsp_mac_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
`ifdef DSP_MAC_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .CEA       (CEA),
        .CEB       (CEB),
        .CEM       (CEM),
        .CEP       (CEP),
        .RSTP      (RSTP),
        .OPMODE    (OPMODE),
        .P_IN      (P_IN),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    // Slice with A/B, M and P registers; accumulates only under the MAC OPMODE
    logic signed [17:0] a_in, b_in, a_r, b_r;
    logic signed [35:0] m_r;
    logic        [47:0] p_r;

    always_ff @(posedge CLK) begin
        if (CEA) a_r <= a_in;
        if (CEB) b_r <= b_in;
        if (CEM) m_r <= a_r * b_r;
        if (RSTP) p_r <= '0;
        else if (CEP && OPMODE == 8'h09) p_r <= p_r + {{12{m_r[35]}}, m_r};
    end
    assign P_IN = p_r;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_ce"}, {CEA, CEB, CEM, CEP}, 0);
        chk({tag, "_rstp"}, RSTP, 0);
        chk({tag, "_opmode"}, OPMODE, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
    endtask

    logic signed [17:0] qa[$];
    logic signed [17:0] qb[$];

    task automatic do_start(input int L);
        @(negedge CLK);
        start = 1'b1;
        len   = L[7:0];
        @(negedge CLK);
        start = 1'b0;
        len   = 8'($urandom);
        #1;
        chk("clear_rstp", RSTP, 1);
        chk("clear_busy", busy, 1);
        chk("clear_in_ready", in_ready, 0);
    endtask

    // gap: 0 continuous, 1 alternate, 2 random. Operands come from qa/qb.
    task automatic run_job(input int L, input int gap, input int stall, input bit busy_start,
                           input bit use_exp, input logic [47:0] exp, input string tag);
        logic [47:0]        model;
        logic signed [47:0] prod;
        int idx, cyc, t;
        model = '0;
        idx   = 0;
        cyc   = 0;
        do_start(L);
        while (idx < L && cyc < 3000) begin
            @(negedge CLK);
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            start = busy_start && (cyc == 1);
            len   = 8'd1;
            a_in  = in_valid ? qa[idx] : 18'($urandom);
            b_in  = in_valid ? qb[idx] : 18'($urandom);
            #1;
            chk({tag, "_feed_ready"}, in_ready, 1);
            chk({tag, "_feed_opmode"}, OPMODE, 8'h09);
            chk({tag, "_cea"}, {CEA, CEB}, {in_valid, in_valid});
            if (in_valid) begin
                prod  = a_in * b_in;
                model = model + prod;
                idx++;
            end
            cyc++;
        end
        if (idx < L) chk({tag, "_feed_timeout"}, idx, L);
        t = 0;
        while (t < 20) begin
            @(negedge CLK);
            in_valid = 1'b0;
            start    = 1'b0;
            #1;
            t++;
            if (t == 1) chk({tag, "_ready_drop"}, in_ready, 0);
            if (res_valid) break;
        end
        chk({tag, "_res_latency"}, t, 4);
        chk({tag, "_res_model"}, res_data, model);
        if (use_exp) chk({tag, "_res_exp"}, res_data, exp);
        for (int s = 0; s < stall; s++) begin
            @(negedge CLK);
            res_ready = 1'b0;
            start     = busy_start;
            len       = 8'd3;
            #1;
            chk({tag, "_stall_valid"}, res_valid, 1);
            chk({tag, "_stall_data"}, res_data, model);
        end
        @(negedge CLK);
        res_ready = 1'b1;
        start     = busy_start;
        len       = 8'd3;
        #1;
        chk({tag, "_hs_valid"}, res_valid, 1);
        @(negedge CLK);
        res_ready = 1'b0;
        start     = 1'b0;
        #1;
        chk({tag, "_after_hs_valid"}, res_valid, 0);
        chk({tag, "_after_hs_busy"}, busy, 0);
    endtask

    typedef struct {
        int     len;
        int     gap;
        int     stall;
        int     a;
        int     b;
        bit     busy_start;
        longint exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic signed [17:0] ta, tb;
        logic [47:0]        te;
        RST = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; res_ready = 1'b0;
        a_in = '0; b_in = '0;
`ifdef DSP_MAC_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0] = '{4,   1, 3, -3,     5,      1'b0, -60};
        vecs[1] = '{255, 0, 0, 1,      1,      1'b0, 255};
        vecs[2] = '{1,   0, 0, 3,      3,      1'b0, 9};
        vecs[3] = '{6,   0, 1, 7,      -2,     1'b1, -84};
        vecs[4] = '{5,   1, 0, -100,   200,    1'b0, -100000};
        vecs[5] = '{2,   0, 0, 131071, 131071, 1'b0, 64'd34359214082};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_all_zero("reset");

        // Basic job: (2*3)+(4*5)+(-1*7) = 19
        qa = '{18'sd2, 18'sd4, -18'sd1};
        qb = '{18'sd3, 18'sd5, 18'sd7};
        run_job(3, 0, 0, 1'b0, 1'b1, 48'd19, "basic");

        foreach (vecs[i]) begin
            qa.delete(); qb.delete();
            ta = vecs[i].a[17:0];
            tb = vecs[i].b[17:0];
            te = vecs[i].exp[47:0];
            for (int k = 0; k < vecs[i].len; k++) begin
                qa.push_back(ta);
                qb.push_back(tb);
            end
            run_job(vecs[i].len, vecs[i].gap, vecs[i].stall, vecs[i].busy_start, 1'b1, te,
                    $sformatf("vec%0d", i));
        end

        // len = 0 is ignored
        @(negedge CLK);
        start = 1'b1; len = 8'd0;
        @(negedge CLK);
        start = 1'b0;
        #1;
        chk("len0_busy", busy, 0);
        chk("len0_rstp", RSTP, 0);

        // Reset on the 2nd accept of a len=5 job
        do_start(5);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            a_in = 18'sd11; b_in = 18'sd13;
            RST = (k == 1);
        end
        @(negedge CLK);
        RST = 1'b0; in_valid = 1'b0;
        #1;
        chk_all_zero("midreset");
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            #1;
            chk("midreset_no_valid", res_valid, 0);
        end
        qa = '{18'sd3};
        qb = '{18'sd3};
        run_job(1, 0, 0, 1'b0, 1'b1, 48'd9, "post_reset");

        // Randomised jobs against the sum-of-products model
        for (int j = 0; j < 8; j++) begin
            int L;
            L = $urandom_range(1, 20);
            qa.delete(); qb.delete();
            for (int k = 0; k < L; k++) begin
                qa.push_back(18'($urandom));
                qb.push_back(18'($urandom));
            end
            run_job(L, 2, $urandom_range(0, 3), 1'($urandom), 1'b0, '0, $sformatf("rnd%0d", j));
        end

`ifdef DSP_MAC_ABORT_EN
        // Abort in DRAIN
        do_start(3);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            a_in = 18'sd5; b_in = 18'sd6;
        end
        @(negedge CLK);
        in_valid = 1'b0;
        abort = 1'b1;
        #1;
        chk("abort_rstp", RSTP, 1);
        @(negedge CLK);
        abort = 1'b0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_ce", {CEM, CEP}, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            #1;
            chk("abort_no_valid", res_valid, 0);
        end
        // Abort in IDLE is a no-op
        @(negedge CLK);
        abort = 1'b1;
        #1;
        chk("abort_idle_rstp", RSTP, 0);
        chk("abort_idle_busy", busy, 0);
        @(negedge CLK);
        abort = 1'b0;
        qa = '{18'sd4, 18'sd2};
        qb = '{18'sd5, -18'sd3};
        run_job(2, 0, 0, 1'b0, 1'b1, 48'd14, "post_abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1-style slice (A/B, M and P pipeline registers, each a register/mux pair with CE) as a length-N multiply-accumulate engine.
- Accepts operand pairs through a valid/ready handshake and drives the slice clock enables, the P register reset and OPMODE.
- When the last product has reached P, it captures the result and presents it with a valid/ready handshake.
- Sits between the sample-stream front end and the DSP slice instance.

Parameters:
- LEN_WIDTH, 8, width of the transfer-length field (N = 1 .. 2^LEN_WIDTH-1).
- P_WIDTH, 48, width of the P accumulator and the result.
- OPMODE_ACC, 8'b0000_1001, OPMODE driven while active (X=M, Z=P, i.e. P <= P + M).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- len  in  LEN_WIDTH  number of operand pairs; sampled with start.
- in_valid  in  1  operand pair present on the slice A/B inputs.
- in_ready  out  1  sequencer accepts the pair this cycle.
- CEA  out  1  A register enable.
- CEB  out  1  B register enable.
- CEM  out  1  M register enable.
- CEP  out  1  P register enable.
- RSTP  out  1  P register synchronous clear.
- OPMODE  out  8  slice OPMODE.
- P_IN  in  P_WIDTH  P output of the slice.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  P_WIDTH  captured accumulation.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: state=IDLE, count=0, len_q=0, ce_sr=2'b00. All outputs are 0: in_ready, CE*, RSTP, OPMODE, res_valid, res_data, busy.
- Reset mid-operation: returns to IDLE on the next edge. Any partially accumulated result is discarded and no res_valid is produced.
- States: IDLE, CLEAR, FEED, DRAIN, RESULT.
- IDLE:
  - start=1 and len!=0 -> latch len into len_q, count<=0, go to CLEAR.
  - start with len=0 is ignored and the block stays in IDLE.
- CLEAR: RSTP=1 for exactly one cycle, then go to FEED.
- FEED:
  - in_ready=1, OPMODE=OPMODE_ACC.
  - accept = in_valid & in_ready.
  - CEA = CEB = accept.
  - count increments on each accept. Gaps in in_valid do not count.
  - When accept occurs with count == len_q-1, go to DRAIN. in_ready drops on the next cycle.
- CE pipeline:
  - ce_sr[0] <= accept and ce_sr[1] <= ce_sr[0].
  - CEM = ce_sr[0] and CEP = ce_sr[1].
  - These stay active in FEED and DRAIN. OPMODE=OPMODE_ACC in FEED and DRAIN, and 0 otherwise.
- DRAIN:
  - in_ready=0.
  - When ce_sr == 0, capture res_data <= P_IN and go to RESULT.
  - With the last accept in cycle t, CEP is high in t+2, capture happens at the end of t+3, and res_valid goes high in t+4.
- RESULT:
  - res_valid=1 and res_data is held stable until res_valid & res_ready.
  - On that handshake, go to IDLE with res_valid=0 the next cycle. No new start is accepted in that same cycle.
- start while busy is ignored. len changes while busy have no effect.
- count width is LEN_WIDTH, and it never wraps because the job ends at len_q.

Optional Feature:
- Macro: DSP_MAC_ABORT_EN.
- With the macro: an extra input port abort (1 bit) is added. abort=1 in any non-IDLE state forces IDLE on the next edge, clears ce_sr and count, and pulses RSTP for one cycle. res_valid is never asserted for an aborted job. abort in IDLE has no effect, and abort has priority over every transition except RST.
- Without the macro: no abort port, and a job always runs to completion.

Decomposition:
- Package dsp_ctrl_pkg holds:
  - the state encoding localparams (IDLE=0, CLEAR=1, FEED=2, DRAIN=3, RESULT=4);
  - OPMODE constants (OPMODE_ACC, OPMODE_IDLE=8'h00).
- Sub-module ce_pipe: 2-stage CE shift register with synchronous reset. It takes accept and outputs CEM/CEP.

Test Plan:
- Basic job: len=3, continuous in_valid, A·B pairs (2·3),(4·5),(−1·7) fed to the slice model.
  - Required: RSTP one cycle after start, in_ready for exactly 3 accepts.
  - res_valid 4 cycles after the last accept, res_data=19.
- Backpressure: len=4 with in_valid low on alternate cycles.
  - Required: exactly 4 CEA pulses, count only on accepts, correct sum.
  - res_valid held across 3 cycles of res_ready=0.
- Length boundaries:
  - len=0 start: block stays IDLE, busy=0.
  - len=255 with all operands 1·1: res_data=255.
- Reset mid-FEED: RST at the 2nd accept of a len=5 job.
  - Required: all outputs 0 on the next cycle, no res_valid.
  - A subsequent len=1 job (3·3) returns 9.
- start while busy: start asserted in FEED and in RESULT is ignored.
  - Back-to-back jobs after a res handshake each clear P (second job result is unaffected by the first).
- DSP_MAC_ABORT_EN build: abort in DRAIN.
  - Required: IDLE on the next cycle, RSTP pulse, ce_sr=0, no res_valid.
  - Abort in IDLE has no effect.
